// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter sharing a JK flip-flop bank among requesters; optional JK_ARB_LOCK_EN
module jk_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDX_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic [NUM_REQ*2-1:0]     req_jk,
`ifdef JK_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [WIDTH-1:0]         q,
  output logic                     grant_valid,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic                     err
);

  // Round-robin pointer and issue stage
  logic [2:0]       ptr_q, ptr_d;
  logic             iss_valid_q, iss_valid_d;
  logic [IDX_W-1:0] iss_idx_q, iss_idx_d;
  logic [1:0]       iss_jk_q, iss_jk_d;
  logic [2:0]       iss_id_q, iss_id_d;

  // JK bank and sticky error
  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;

  // Arbitration results
  logic             xfer;
  logic             lock_win;
  logic [2:0]       win_id;
  logic [IDX_W-1:0] win_idx;
  logic [1:0]       win_jk;

`ifdef JK_ARB_LOCK_EN
  // Set once any transfer has happened, so iss_id_q names a real previous owner
  logic             have_last_q, have_last_d;
`endif

  // Pick the winner: a held lock first, otherwise the first valid requester from the pointer
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    lock_win  = 1'b0;
    win_id    = '0;
    win_idx   = '0;
    win_jk    = '0;
    ptr_d     = ptr_q;

`ifdef JK_ARB_LOCK_EN
    if (have_last_q) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == int'(iss_id_q) && req_valid[i] && req_lock[i]) begin
          lock_win = 1'b1;
          xfer     = 1'b1;
          win_id   = iss_id_q;
        end
      end
    end
`endif

    if (!xfer) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!xfer && i == (int'(ptr_q) + k) % NUM_REQ && req_valid[i]) begin
            xfer   = 1'b1;
            win_id = 3'(i);
          end
        end
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && i == int'(win_id)) begin
        req_ready[i] = 1'b1;
        win_idx      = req_idx[i*IDX_W +: IDX_W];
        win_jk       = req_jk[i*2 +: 2];
      end
    end

    // A locked re-grant leaves the rotation where it was
    if (xfer && !lock_win) begin
      ptr_d = 3'((int'(win_id) + 1) % NUM_REQ);
    end
  end

  // Stage 1: capture the granted command; stage 2: apply the issue-stage command to the bank
  always_comb begin
    iss_valid_d = xfer;
    iss_idx_d   = iss_idx_q;
    iss_jk_d    = iss_jk_q;
    iss_id_d    = iss_id_q;
    q_d         = q_q;
    err_d       = err_q;

    if (xfer) begin
      iss_idx_d = win_idx;
      iss_jk_d  = win_jk;
      iss_id_d  = win_id;
    end

    if (iss_valid_q) begin
      if (int'(iss_idx_q) < WIDTH) begin
        for (int b = 0; b < WIDTH; b++) begin
          if (int'(iss_idx_q) == b) begin
            case (iss_jk_q)
              2'b01:   q_d[b] = 1'b0;
              2'b10:   q_d[b] = 1'b1;
              2'b11:   q_d[b] = ~q_q[b];
              default: q_d[b] = q_q[b];
            endcase
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

`ifdef JK_ARB_LOCK_EN
  // Remember that a previous transfer exists for lock ownership
  always_comb begin
    have_last_d = have_last_q | xfer;
  end

  // Lock ownership register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_last_q <= 1'b0;
    end else begin
      have_last_q <= have_last_d;
    end
  end
`endif

  // State registers; reset discards the issue stage and clears the bank at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      iss_jk_q    <= '0;
      iss_id_q    <= '0;
      q_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_idx_q   <= iss_idx_d;
      iss_jk_q    <= iss_jk_d;
      iss_id_q    <= iss_id_d;
      q_q         <= q_d;
      err_q       <= err_d;
    end
  end

  assign q           = q_q;
  assign grant_valid = iss_valid_q;
  assign grant_id    = iss_id_q;
  assign busy        = iss_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - directed self-checking bench for jk_bank_arbiter (WIDTH = 6)
module tb_jk_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_idx;
  logic [7:0]  req_jk;
`ifdef JK_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic [5:0]  q;
  logic        grant_valid;
  logic [2:0]  grant_id;
  logic        busy;
  logic        err;

  int n_chk;
  int n_pass;

  jk_bank_arbiter #(.NUM_REQ(4), .WIDTH(6), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_idx     (req_idx),
    .req_jk      (req_jk),
`ifdef JK_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .q           (q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] idx, input logic [1:0] jk);
    req_idx[i*3 +: 3] = idx;
    req_jk[i*2 +: 2]  = jk;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_idx   = '0;
    req_jk    = '0;
`ifdef JK_ARB_LOCK_EN
    req_lock  = '0;
`endif

    // Reset state
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_gv", 32'(grant_valid), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Requester 2: idx 3 set, toggle, clear
    set_req(2, 3'd3, 2'b10);
    req_valid = 4'b0100;
    #1;
    check("r2_ready", 32'(req_ready), 32'h4);
    tick();
    check("r2_gv", 32'(grant_valid), 32'h1);
    check("r2_gid0", 32'(grant_id), 32'h2);
    check("r2_q0", 32'(q), 32'h00);
    set_req(2, 3'd3, 2'b11);
    tick();
    check("r2_q_set", 32'(q), 32'h08);
    check("r2_gid1", 32'(grant_id), 32'h2);
    set_req(2, 3'd3, 2'b01);
    tick();
    check("r2_q_tog", 32'(q), 32'h00);
    check("r2_gid2", 32'(grant_id), 32'h2);
    req_valid = '0;
    tick();
    check("r2_q_clr", 32'(q), 32'h00);
    check("r2_gid3", 32'(grant_id), 32'h2);
    check("r2_gv_end", 32'(grant_valid), 32'h0);

    // Pointer is 3; a lone requester 1 wins and moves it to 2
    set_req(1, 3'd0, 2'b10);
    req_valid = 4'b0010;
    #1;
    check("r1_ready", 32'(req_ready), 32'h2);
    tick();

    // Requesters 1 and 3 with pointer 2: 3 first, then 1
    set_req(3, 3'd1, 2'b10);
    set_req(1, 3'd2, 2'b11);
    req_valid = 4'b1010;
    #1;
    check("p2_ready3", 32'(req_ready), 32'h8);
    tick();
    check("p2_gid3", 32'(grant_id), 32'h3);
    check("p2_q_a", 32'(q), 32'h01);
    req_valid = 4'b0010;
    #1;
    check("p2_ready1", 32'(req_ready), 32'h2);
    tick();
    check("p2_gid1", 32'(grant_id), 32'h1);
    check("p2_q_b", 32'(q), 32'h03);
    req_valid = '0;
    tick();
    check("p2_q_c", 32'(q), 32'h07);
    check("p2_gv_end", 32'(grant_valid), 32'h0);

    // Pointer ended at 2: all valid picks requester 2; then reset with it pending
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 2'b11);
    req_valid = 4'b1111;
    #1;
    check("ptr_end2", 32'(req_ready), 32'h4);
    tick();
    check("pend_gv", 32'(grant_valid), 32'h1);
    check("pend_gid", 32'(grant_id), 32'h2);
    check("pend_q", 32'(q), 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_gv", 32'(grant_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    check("arst_gid", 32'(grant_id), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;

    // Fairness: all four valid for 8 cycles, each bit toggled twice
    for (int k = 0; k < 8; k++) begin
      check("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check("rr_gid", 32'(grant_id), 32'(k % 4));
      if (k == 3) check("rr_q_mid", 32'(q), 32'h07);
    end
    req_valid = '0;
    tick();
    check("rr_q_end", 32'(q), 32'h00);
    check("rr_gv_end", 32'(grant_valid), 32'h0);

    // Requester 0: idx 5 set, idx 5 hold, then out-of-range idx 6
    set_req(0, 3'd5, 2'b10);
    req_valid = 4'b0001;
    tick();
    set_req(0, 3'd5, 2'b00);
    tick();
    check("oor_q_set", 32'(q), 32'h20);
    check("oor_err0", 32'(err), 32'h0);
    set_req(0, 3'd6, 2'b10);
    tick();
    check("oor_q_hold", 32'(q), 32'h20);
    check("oor_err1", 32'(err), 32'h0);
    check("oor_gid", 32'(grant_id), 32'h0);
    req_valid = '0;
    tick();
    check("oor_q_apply", 32'(q), 32'h20);
    check("oor_err_rise", 32'(err), 32'h1);
    tick();
    check("oor_err_sticky", 32'(err), 32'h1);
    check("oor_gv_end", 32'(grant_valid), 32'h0);

`ifdef JK_ARB_LOCK_EN
    // Requester 1 locks for three commands while requester 2 waits
    set_req(1, 3'd1, 2'b00);
    set_req(2, 3'd2, 2'b00);
    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("lock_ready", 32'(req_ready), 32'h2);
      tick();
      check("lock_gid", 32'(grant_id), 32'h1);
    end
    req_valid = 4'b0100;
    req_lock  = '0;
    #1;
    check("unlock_ready", 32'(req_ready), 32'h4);
    tick();
    check("unlock_gid", 32'(grant_id), 32'h2);
    req_valid = '0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
